// File: rtl/lgu_pkg.sv
// Shared definitions for the logic gate unit: gate-select encodings and pipeline depth.
package lgu_pkg;

    localparam logic [2:0] LGU_AND   = 3'b000;
    localparam logic [2:0] LGU_OR    = 3'b001;
    localparam logic [2:0] LGU_XOR   = 3'b010;
    localparam logic [2:0] LGU_NAND  = 3'b011;
    localparam logic [2:0] LGU_NOR   = 3'b100;
    localparam logic [2:0] LGU_XNOR  = 3'b101;
    localparam logic [2:0] LGU_NOTA  = 3'b110;
    localparam logic [2:0] LGU_PASSB = 3'b111;

    localparam int LGU_LATENCY = 2;

endpackage

// File: rtl/lgu_stage.sv
// One valid/ready pipeline register: loads when empty or when downstream drains it,
// otherwise holds its payload stable.
module lgu_stage #(
    parameter int PW = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          valid;
    logic [PW-1:0] data;

    // Empty slots accept regardless of downstream, so bubbles collapse.
    assign in_ready  = !valid || out_ready;
    assign out_valid = valid;
    assign out_data  = data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid <= 1'b0;
            // NOTE: the payload is reset as well so the visible result reads zero
            // out of reset instead of stale or X data.
            data  <= '0;
        end else if (in_ready) begin
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_gate_unit_pipe.sv
// Two-stage valid/ready bitwise gate unit with a delivered-result counter.
// Define LGU_FLAGS_EN to add registered zero/parity flags on the result.
module logic_gate_unit_pipe
    import lgu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_par,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int S1_W = 2*WIDTH + 3;

`ifdef LGU_FLAGS_EN
    localparam int S2_W = WIDTH + 2;
`else
    localparam int S2_W = WIDTH;
`endif

    logic             s1_valid;
    logic             s2_in_ready;
    logic [S1_W-1:0]  s1_data;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] gate;
    logic [S2_W-1:0]  s2_in;
    logic [S2_W-1:0]  s2_data;

    lgu_stage #(.PW(S1_W)) u_s1 (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({op, a, b}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign s1_b  = s1_data[WIDTH-1:0];
    assign s1_a  = s1_data[2*WIDTH-1:WIDTH];
    assign s1_op = s1_data[S1_W-1 -: 3];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gate = '0;
        case (s1_op)
            LGU_AND:   gate = s1_a & s1_b;
            LGU_OR:    gate = s1_a | s1_b;
            LGU_XOR:   gate = s1_a ^ s1_b;
            LGU_NAND:  gate = ~(s1_a & s1_b);
            LGU_NOR:   gate = ~(s1_a | s1_b);
            LGU_XNOR:  gate = ~(s1_a ^ s1_b);
            LGU_NOTA:  gate = ~s1_a;
            LGU_PASSB: gate = s1_b;
            default:   gate = '0;
        endcase
    end

`ifdef LGU_FLAGS_EN
    assign s2_in = {^gate, ~|gate, gate};
`else
    assign s2_in = gate;
`endif

    lgu_stage #(.PW(S2_W)) u_s2 (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign result = s2_data[WIDTH-1:0];

`ifdef LGU_FLAGS_EN
    assign flag_zero = s2_data[WIDTH];
    assign flag_par  = s2_data[WIDTH+1];
`else
    assign flag_zero = 1'b0;
    assign flag_par  = 1'b0;
`endif

    // Counts output transfers; wraps silently at full scale.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule
